// File: rtl/otter_mmio_pkg.sv
// Shared OTTER MMIO map: keyboard FIFO addresses and CTRL register bit positions.
package otter_mmio_pkg;

   localparam logic [31:0] DATA_AD   = 32'h1120_0000;
   localparam logic [31:0] STATUS_AD = 32'h1124_0000;
   localparam logic [31:0] CTRL_AD   = 32'h1124_0000;

   localparam int POP_BIT   = 0;
   localparam int FLUSH_BIT = 1;

endpackage

// File: rtl/kbd_scancode_fifo_if.sv
// Keyboard scancode input plus MCU IOBUS read/write signals for the scancode FIFO.
interface kbd_scancode_fifo_if;

   logic        scan_stb;
   logic [7:0]  scancode;
   logic [31:0] iobus_addr;
   logic [31:0] iobus_out;
   logic        iobus_wr;
   logic [31:0] rd_data;
   logic        intr;

   modport master (
      output scan_stb, scancode, iobus_addr, iobus_out, iobus_wr,
      input  rd_data, intr
   );

   modport slave (
      input  scan_stb, scancode, iobus_addr, iobus_out, iobus_wr,
      output rd_data, intr
   );

endinterface

// File: rtl/kbd_scancode_fifo_edge_detect_rise.sv
// One-cycle pulse on a rising edge of i_sig; the reset value of the history bit is settable.
module edge_detect_rise #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_pulse
);

   logic r_prev;

   // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_prev <= RST_VAL;
      else       r_prev <= i_sig;
   end

   assign o_pulse = i_sig & ~r_prev;

endmodule

// File: rtl/kbd_scancode_fifo.sv
// PS/2 scancode FIFO exposed as MMIO head/status reads and a POP/FLUSH control write.
// Define KBD_FIFO_OVF_CNT_EN to report a saturating dropped-byte count in STATUS[31:24].
module kbd_scancode_fifo
   import otter_mmio_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   kbd_scancode_fifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_ovf, r_intr;

   logic          w_push, w_wr_ctrl, w_flush, w_pop, w_push_ok, w_drop;
   logic          w_empty, w_full;
   logic [AW:0]   w_count_next;
   logic [7:0]    w_ovf_hi;
   logic [31:0]   w_status;

   // Prev register resets to 1 so a strobe already high at reset release is not a push.
   edge_detect_rise #(.RST_VAL(1'b1)) u_stb_edge (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_sig   (bus.scan_stb),
      .o_pulse (w_push)
   );

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_FULL);
   assign w_wr_ctrl = bus.iobus_wr && (bus.iobus_addr == CTRL_AD);
   assign w_flush   = w_wr_ctrl && bus.iobus_out[FLUSH_BIT];
   assign w_pop     = w_wr_ctrl && bus.iobus_out[POP_BIT] && !w_flush && !w_empty;
   assign w_push_ok = w_push && !w_flush && (!w_full || w_pop);
   assign w_drop    = w_push && !w_flush && w_full && !w_pop;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_count_next = r_count;
      if (w_push_ok && !w_pop)      w_count_next = r_count + CNT_ONE;
      else if (w_pop && !w_push_ok) w_count_next = r_count - CNT_ONE;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_intr   <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_drop)    r_ovf    <= 1'b1;
         r_count <= w_count_next;
         r_intr  <= (w_push_ok && w_empty) || (w_pop && (w_count_next != '0));
      end
   end

   // NOTE: storage has no reset; contents are only visible through the pointers, which do reset.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= bus.scancode;
   end

`ifdef KBD_FIFO_OVF_CNT_EN
   logic [7:0] r_ovf_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || w_flush)                r_ovf_cnt <= '0;
      else if (w_drop && r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 8'd1;
   end

   assign w_ovf_hi = r_ovf_cnt;
`else
   assign w_ovf_hi = 8'h00;
`endif

   assign w_status = {w_ovf_hi, 8'h00, 8'(r_count), 5'b0, r_ovf, w_full, w_empty};

   always_comb begin
      bus.rd_data = 32'h0;
      if (bus.iobus_addr == DATA_AD) begin
         if (!w_empty) bus.rd_data = {24'h0, r_mem[r_rd_ptr]};
      end else if (bus.iobus_addr == STATUS_AD) begin
         bus.rd_data = w_status;
      end
   end

   assign bus.intr = r_intr;

endmodule

// File: tb/tb_kbd_scancode_fifo.sv
// Directed self-checking bench for kbd_scancode_fifo (DEPTH=8), both macro builds.
module tb_kbd_scancode_fifo;
   import otter_mmio_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   intr_cnt = 0;

   kbd_scancode_fifo_if bus ();

   kbd_scancode_fifo #(.DEPTH(8)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.intr === 1'b1) intr_cnt++;

`ifdef KBD_FIFO_OVF_CNT_EN
   localparam logic [31:0] OVF_HI = 32'h0100_0000;
`else
   localparam logic [31:0] OVF_HI = 32'h0000_0000;
`endif

   task automatic cycle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic read_word(input logic [31:0] addr, output logic [31:0] data);
      bus.iobus_addr = addr;
      #1;
      data = bus.rd_data;
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      bus.scan_stb = 1'b1;
      bus.scancode = b;
      @(negedge clk);
      bus.scan_stb = 1'b0;
   endtask

   task automatic ctrl_write(input logic [31:0] val);
      @(negedge clk);
      bus.iobus_addr = CTRL_AD;
      bus.iobus_out  = val;
      bus.iobus_wr   = 1'b1;
      @(negedge clk);
      bus.iobus_wr   = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      bus.scan_stb = 1'b0; bus.scancode = 8'h00;
      bus.iobus_addr = 32'h0; bus.iobus_out = 32'h0; bus.iobus_wr = 1'b0;
      rst = 1'b1;
      cycle(3);
      rst = 1'b0;
      cycle(3);
      read_word(STATUS_AD, d);
      checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h1); end
      read_word(DATA_AD, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", d); end
      read_word(32'h1000_0000, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL foreign_addr: got %h expected 0", d); end
      checks++; if (intr_cnt !== 0) begin errors++; $display("FAIL reset_intr: got %0d pulses expected 0", intr_cnt); end
   endtask

   task automatic test_held_strobe;
      logic [31:0] d;
      int base;
      base = intr_cnt;
      @(negedge clk);
      bus.scan_stb = 1'b1; bus.scancode = 8'h1C;
      cycle(5);
      bus.scan_stb = 1'b0;
      cycle(2);
      read_word(STATUS_AD, d);
      checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL held_status: got %h expected %h", d, 32'h100); end
      read_word(DATA_AD, d);
      checks++; if (d !== 32'h0000_001C) begin errors++; $display("FAIL held_data: got %h expected %h", d, 32'h1C); end
      checks++; if (intr_cnt - base !== 1) begin errors++; $display("FAIL held_intr: got %0d pulses expected 1", intr_cnt - base); end
      ctrl_write(32'h1);
      cycle(1);
      checks++; if (intr_cnt - base !== 1) begin errors++; $display("FAIL last_pop_intr: got %0d pulses expected 1", intr_cnt - base); end
   endtask

   task automatic test_pop_sequence;
      logic [31:0] d;
      int base;
      base = intr_cnt;
      push_byte(8'h1C); push_byte(8'h32); push_byte(8'h21);
      cycle(1);
      checks++; if (intr_cnt - base !== 1) begin errors++; $display("FAIL push_empty_intr: got %0d expected 1", intr_cnt - base); end
      ctrl_write(32'h1);
      read_word(DATA_AD, d);
      checks++; if (d !== 32'h32) begin errors++; $display("FAIL pop1_data: got %h expected %h", d, 32'h32); end
      checks++; if (intr_cnt - base !== 2) begin errors++; $display("FAIL pop1_intr: got %0d expected 2", intr_cnt - base); end
      ctrl_write(32'h1);
      read_word(DATA_AD, d);
      checks++; if (d !== 32'h21) begin errors++; $display("FAIL pop2_data: got %h expected %h", d, 32'h21); end
      checks++; if (intr_cnt - base !== 3) begin errors++; $display("FAIL pop2_intr: got %0d expected 3", intr_cnt - base); end
      ctrl_write(32'h1);
      cycle(1);
      read_word(STATUS_AD, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL pop3_status: got %h expected %h", d, 32'h1); end
      checks++; if (intr_cnt - base !== 3) begin errors++; $display("FAIL pop3_intr: got %0d expected 3", intr_cnt - base); end
      ctrl_write(32'h1);
      cycle(1);
      read_word(STATUS_AD, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL pop_empty_status: got %h expected %h", d, 32'h1); end
      read_word(DATA_AD, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL pop_empty_data: got %h expected 0", d); end
      checks++; if (intr_cnt - base !== 3) begin errors++; $display("FAIL pop_empty_intr: got %0d expected 3", intr_cnt - base); end
   endtask

   task automatic test_overflow;
      logic [31:0] d;
      int base;
      base = intr_cnt;
      for (int i = 1; i <= 9; i++) push_byte(8'(i));
      cycle(1);
      read_word(STATUS_AD, d);
      checks++; if (d !== (OVF_HI | 32'h0000_0806)) begin errors++; $display("FAIL ovf_status: got %h expected %h", d, OVF_HI | 32'h806); end
      read_word(DATA_AD, d);
      checks++; if (d !== 32'h01) begin errors++; $display("FAIL ovf_head: got %h expected %h", d, 32'h1); end
      checks++; if (intr_cnt - base !== 1) begin errors++; $display("FAIL ovf_intr: got %0d expected 1", intr_cnt - base); end
   endtask

   task automatic test_full_push_pop;
      logic [31:0] d;
      int base;
      base = intr_cnt;
      @(negedge clk);
      bus.scan_stb = 1'b1; bus.scancode = 8'h09;
      bus.iobus_addr = CTRL_AD; bus.iobus_out = 32'h1; bus.iobus_wr = 1'b1;
      @(negedge clk);
      bus.scan_stb = 1'b0; bus.iobus_wr = 1'b0;
      read_word(STATUS_AD, d);
      checks++; if (d !== (OVF_HI | 32'h0000_0806)) begin errors++; $display("FAIL full_pp_status: got %h expected %h", d, OVF_HI | 32'h806); end
      checks++; if (intr_cnt - base !== 1) begin errors++; $display("FAIL full_pp_intr: got %0d expected 1", intr_cnt - base); end
      for (int i = 2; i <= 9; i++) begin
         read_word(DATA_AD, d);
         checks++; if (d !== 32'(i)) begin errors++; $display("FAIL drain_%0d: got %h expected %h", i, d, 32'(i)); end
         ctrl_write(32'h1);
      end
      cycle(1);
      read_word(STATUS_AD, d);
      checks++; if (d !== (OVF_HI | 32'h0000_0005)) begin errors++; $display("FAIL drained_status: got %h expected %h", d, OVF_HI | 32'h5); end
      checks++; if (intr_cnt - base !== 8) begin errors++; $display("FAIL drain_intr: got %0d expected 8", intr_cnt - base); end
   endtask

   task automatic test_flush;
      logic [31:0] d;
      int base;
      push_byte(8'h55); push_byte(8'h66);
      cycle(1);
      base = intr_cnt;
      @(negedge clk);
      bus.scan_stb = 1'b1; bus.scancode = 8'h77;
      bus.iobus_addr = CTRL_AD; bus.iobus_out = 32'h3; bus.iobus_wr = 1'b1;
      @(negedge clk);
      bus.scan_stb = 1'b0; bus.iobus_wr = 1'b0;
      cycle(1);
      read_word(STATUS_AD, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL flush_status: got %h expected %h", d, 32'h1); end
      read_word(DATA_AD, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL flush_data: got %h expected 0", d); end
      checks++; if (intr_cnt - base !== 0) begin errors++; $display("FAIL flush_intr: got %0d expected 0", intr_cnt - base); end
   endtask

   task automatic test_reset_mid_burst;
      logic [31:0] d;
      int base;
      push_byte(8'hAA); push_byte(8'hBB);
      @(negedge clk);
      bus.scan_stb = 1'b1; bus.scancode = 8'hCC; rst = 1'b1;
      cycle(2);
      rst = 1'b0;
      base = intr_cnt;
      cycle(3);
      read_word(STATUS_AD, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL rst_mid_status: got %h expected %h", d, 32'h1); end
      checks++; if (intr_cnt - base !== 0) begin errors++; $display("FAIL rst_mid_intr: got %0d expected 0", intr_cnt - base); end
      bus.scan_stb = 1'b0;
      push_byte(8'hDD);
      cycle(1);
      read_word(STATUS_AD, d);
      checks++; if (d !== 32'h100) begin errors++; $display("FAIL post_rst_status: got %h expected %h", d, 32'h100); end
      read_word(DATA_AD, d);
      checks++; if (d !== 32'hDD) begin errors++; $display("FAIL post_rst_data: got %h expected %h", d, 32'hDD); end
   endtask

   initial begin
      test_reset();
      test_held_strobe();
      test_pop_sequence();
      test_overflow();
      test_full_push_pop();
      test_flush();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
